// File: rtl/wsram_pkg.sv
// Shared types and sizes for the weight SRAM controller.
package wsram_pkg;

  localparam int ADDR_W    = 6;
  localparam int ROW_W     = 512;
  localparam int SRAM_ROWS = 64;
  localparam int LEN_W     = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // A requested length of zero means a full sweep of the array.
  function automatic logic [LEN_W-1:0] burst_len(input logic [LEN_W-1:0] len);
    return (len == '0) ? LEN_W'(SRAM_ROWS) : len;
  endfunction

endpackage

// File: rtl/wsram_out_fifo.sv
// Small synchronous FIFO holding SRAM rows until the array accepts them.
module wsram_out_fifo #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 3,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    do_pop  = pop && (count_q != '0);
    wptr_d  = push ? ptr_inc(wptr_q) : wptr_q;
    rptr_d  = do_pop ? ptr_inc(rptr_q) : rptr_q;
    count_d = count_q;
    if (push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push && do_pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Row storage carries no reset; emptiness is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= push_data;
    end
  end

  assign head_valid = (count_q != '0);
  assign head_data  = head_valid ? mem_q[rptr_q] : '0;
  assign count      = count_q;

endmodule

// File: rtl/weight_sram_ctrl.sv
// Weight SRAM controller: loader writes, credit-paced read bursts, output FIFO.
// Define WSRAM_CTRL_PERF_EN to add saturating stall/wait performance counters.
module weight_sram_ctrl #(
  parameter int FIFO_DEPTH = 3,
  parameter int ADDR_W     = wsram_pkg::ADDR_W,
  parameter int ROW_W      = wsram_pkg::ROW_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ROW_W-1:0]  wr_data,
  input  logic              rd_start,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [ADDR_W:0]   rd_len,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ROW_W-1:0]  out_data,
  output logic              done,
  output logic              sram_csb,
  output logic              sram_wsb,
  output logic [ADDR_W-1:0] sram_waddr,
  output logic [ADDR_W-1:0] sram_raddr,
  output logic [ROW_W-1:0]  sram_wdata,
`ifdef WSRAM_CTRL_PERF_EN
  output logic [31:0]       perf_rd_stall,
  output logic [31:0]       perf_wr_wait,
`endif
  input  logic [ROW_W-1:0]  sram_rdata
);

  import wsram_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LEN_W-1:0]  issue_rem_q, issue_rem_d;
  logic [LEN_W-1:0]  pop_rem_q, pop_rem_d;
  logic              inflight_q, inflight_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  fifo_count;
  logic              credit_ok, rd_issue, wr_grant, out_hs;

  always_comb begin
    // A row issued last cycle still owns a FIFO slot until it lands.
    credit_ok   = (int'(fifo_count) + int'(inflight_q)) < FIFO_DEPTH;
    rd_issue    = (state_q == ISSUE) && credit_ok;
    wr_grant    = wr_valid && !rd_issue;
    out_hs      = out_valid && out_ready;

    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    issue_rem_d = issue_rem_q;
    pop_rem_d   = pop_rem_q;
    inflight_d  = rd_issue;
    done_d      = 1'b0;

    if (rd_issue) begin
      rd_ptr_d    = rd_ptr_q + ADDR_W'(1);
      issue_rem_d = issue_rem_q - LEN_W'(1);
    end
    if (out_hs) begin
      pop_rem_d = pop_rem_q - LEN_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (rd_start) begin
          state_d     = ISSUE;
          rd_ptr_d    = rd_base;
          issue_rem_d = burst_len(rd_len);
          pop_rem_d   = burst_len(rd_len);
        end
      end
      ISSUE: begin
        if (rd_issue && (issue_rem_q == LEN_W'(1))) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_hs && (pop_rem_q == LEN_W'(1))) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rd_ptr_q    <= '0;
      issue_rem_q <= '0;
      pop_rem_q   <= '0;
      inflight_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      issue_rem_q <= issue_rem_d;
      pop_rem_q   <= pop_rem_d;
      inflight_q  <= inflight_d;
      done_q      <= done_d;
    end
  end

  wsram_out_fifo #(
    .WIDTH (ROW_W),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (inflight_q),
    .push_data  (sram_rdata),
    .pop        (out_ready),
    .head_valid (out_valid),
    .head_data  (out_data),
    .count      (fifo_count)
  );

  assign wr_ready   = wr_grant;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign sram_csb   = !(rd_issue || wr_grant);
  assign sram_wsb   = !wr_grant;
  assign sram_raddr = rd_issue ? rd_ptr_q : '0;
  assign sram_waddr = wr_grant ? wr_addr : '0;
  assign sram_wdata = wr_grant ? wr_data : '0;

`ifdef WSRAM_CTRL_PERF_EN
  logic [31:0] perf_rd_stall_q, perf_rd_stall_d;
  logic [31:0] perf_wr_wait_q, perf_wr_wait_d;

  always_comb begin
    perf_rd_stall_d = perf_rd_stall_q;
    perf_wr_wait_d  = perf_wr_wait_q;
    if ((state_q == ISSUE) && !rd_issue && (perf_rd_stall_q != '1)) begin
      perf_rd_stall_d = perf_rd_stall_q + 32'd1;
    end
    if (wr_valid && !wr_grant && (perf_wr_wait_q != '1)) begin
      perf_wr_wait_d = perf_wr_wait_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_rd_stall_q <= '0;
      perf_wr_wait_q  <= '0;
    end else begin
      perf_rd_stall_q <= perf_rd_stall_d;
      perf_wr_wait_q  <= perf_wr_wait_d;
    end
  end

  assign perf_rd_stall = perf_rd_stall_q;
  assign perf_wr_wait  = perf_wr_wait_q;
`endif

endmodule

// File: tb/tb_weight_sram_ctrl.sv
// Bench for weight_sram_ctrl: SRAM model, behavioural reference, directed and random traffic.
`timescale 1ns/1ps
module tb_weight_sram_ctrl;

  localparam int AW = 6;
  localparam int RW = 512;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [AW-1:0] wr_addr = '0;
  logic [RW-1:0] wr_data = '0;
  logic          rd_start = 1'b0;
  logic [AW-1:0] rd_base = '0;
  logic [AW:0]   rd_len = '0;
  logic          busy, out_valid, done;
  logic          out_ready = 1'b0;
  logic [RW-1:0] out_data;
  logic          sram_csb, sram_wsb;
  logic [AW-1:0] sram_waddr, sram_raddr;
  logic [RW-1:0] sram_wdata;
  logic [RW-1:0] sram_rdata;
`ifdef WSRAM_CTRL_PERF_EN
  logic [31:0]   perf_rd_stall, perf_wr_wait;
`endif

  always #5 clk = ~clk;

  weight_sram_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_start   (rd_start),
    .rd_base    (rd_base),
    .rd_len     (rd_len),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .done       (done),
    .sram_csb   (sram_csb),
    .sram_wsb   (sram_wsb),
    .sram_waddr (sram_waddr),
    .sram_raddr (sram_raddr),
    .sram_wdata (sram_wdata),
`ifdef WSRAM_CTRL_PERF_EN
    .perf_rd_stall (perf_rd_stall),
    .perf_wr_wait  (perf_wr_wait),
`endif
    .sram_rdata (sram_rdata)
  );

  // SRAM macro model: 1-cycle registered read.
  logic [RW-1:0] sram_mem [64];
  always @(posedge clk) begin
    if (!sram_csb && !sram_wsb) sram_mem[sram_waddr] <= sram_wdata;
    if (!sram_csb && sram_wsb)  sram_rdata <= sram_mem[sram_raddr];
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [RW-1:0] data;
    int            avail;
  } ent_t;

  ent_t          q[$];
  logic [RW-1:0] shadow [64];
  bit            m_active = 1'b0;
  bit            m_done = 1'b0;
  int            m_base, m_len, m_issued, m_popped;
  int            issue_log[$];
  int            hs_log[$];
  int            done_log[$];
  logic [RW-1:0] hs_data[$];
  int            start_cyc = 0;
  int            wsb_low_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic chkrow(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] pat(input int r);
    logic [31:0] w;
    w = 32'hA500_0000 + 32'(r);
    return {16{w}};
  endfunction

  function automatic logic [RW-1:0] rand_row();
    logic [RW-1:0] v;
    for (int k = 0; k < 16; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // Reference model and per-cycle compare, sampled mid-cycle.
  always @(negedge clk) begin : cmp
    bit exp_iss, exp_wr, exp_vld, start_acc, done_nxt;
    int addr;
    if (rst) begin
      m_active = 1'b0;
      m_done   = 1'b0;
      q.delete();
    end else begin
      exp_iss = m_active && (m_issued < m_len) && ((m_issued - m_popped) < 3);
      addr    = (m_base + m_issued) % 64;
      exp_wr  = wr_valid && !exp_iss;
      exp_vld = 1'b0;
      if (q.size() > 0) exp_vld = (q[0].avail <= cyc);

      chk("rd_issue", 64'(!sram_csb && sram_wsb), 64'(exp_iss));
      if (exp_iss) chk("raddr", 64'(sram_raddr), 64'(addr));
      chk("wr_ready", 64'(wr_ready), 64'(exp_wr));
      chk("wr_strobe", 64'(!sram_csb && !sram_wsb), 64'(exp_wr));
      chk("csb", 64'(sram_csb), 64'(!(exp_iss || exp_wr)));
      if (exp_wr) begin
        chk("waddr", 64'(sram_waddr), 64'(wr_addr));
        chkrow("wdata", sram_wdata, wr_data);
      end
      chk("busy", 64'(busy), 64'(m_active));
      chk("out_valid", 64'(out_valid), 64'(exp_vld));
      if (exp_vld) chkrow("out_data", out_data, q[0].data);
      chk("done", 64'(done), 64'(m_done));

      if (!sram_csb && sram_wsb) issue_log.push_back(int'(sram_raddr));
      if (!sram_wsb) wsb_low_cnt++;
      if (done) done_log.push_back(cyc);

      start_acc = !m_active && rd_start;
      done_nxt  = 1'b0;
      if (exp_iss) begin
        q.push_back('{shadow[addr], cyc + 2});
        m_issued++;
      end
      if (exp_wr) shadow[wr_addr] = wr_data;
      if (exp_vld && out_ready) begin
        hs_log.push_back(cyc);
        hs_data.push_back(out_data);
        void'(q.pop_front());
        m_popped++;
        if (m_popped == m_len) begin
          m_active = 1'b0;
          done_nxt = 1'b1;
        end
      end
      if (start_acc) begin
        m_active  = 1'b1;
        m_base    = int'(rd_base);
        m_len     = (rd_len == '0) ? 64 : int'(rd_len);
        m_issued  = 0;
        m_popped  = 0;
        start_cyc = cyc;
      end
      m_done = done_nxt;
    end
    cyc++;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    issue_log.delete();
    hs_log.delete();
    done_log.delete();
    hs_data.delete();
    wsb_low_cnt = 0;
  endtask

  task automatic start_burst(input int base, input int len);
    rd_start = 1'b1;
    rd_base  = AW'(base);
    rd_len   = 7'(len);
    tick();
    rd_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL wait_idle cycle %0d: busy still 1 after %0d cycles", cyc, budget);
    end
    tick(2);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_wr_ready"}, 64'(wr_ready), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_csb"}, 64'(sram_csb), 64'(1));
    chk({tag, "_wsb"}, 64'(sram_wsb), 64'(1));
    chk({tag, "_raddr"}, 64'(sram_raddr), 64'(0));
    chk({tag, "_waddr"}, 64'(sram_waddr), 64'(0));
    chkrow({tag, "_wdata"}, sram_wdata, '0);
    chkrow({tag, "_out_data"}, out_data, '0);
`ifdef WSRAM_CTRL_PERF_EN
    chk({tag, "_perf_rd_stall"}, 64'(perf_rd_stall), 64'(0));
    chk({tag, "_perf_wr_wait"}, 64'(perf_wr_wait), 64'(0));
`endif
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      sram_mem[i] = '0;
      shadow[i]   = '0;
    end

    // Reset values.
    @(negedge clk);
    #1;
    check_reset_vals("reset");
    tick();
    rst = 1'b0;
    tick();

    // Preload every row through the loader port.
    for (int r = 0; r < 64; r++) begin
      wr_valid = 1'b1;
      wr_addr  = AW'(r);
      wr_data  = pat(r);
      tick();
    end
    wr_valid = 1'b0;
    tick();

    // Basic burst timing with a free-running consumer.
    out_ready = 1'b1;
    clear_logs();
    start_burst(0, 4);
    wait_idle(50);
    chk("t1_rows", 64'(hs_log.size()), 64'(4));
    chk("t1_first_lat", 64'(hs_log[0] - start_cyc), 64'(3));
    chk("t1_last_lat", 64'(hs_log[3] - start_cyc), 64'(6));
    chk("t1_done_lat", 64'(done_log[0] - start_cyc), 64'(7));
    chk("t1_done_cnt", 64'(done_log.size()), 64'(1));
    chk("t1_no_write", 64'(wsb_low_cnt), 64'(0));
    chkrow("t1_row0", hs_data[0], pat(0));
    chkrow("t1_row3", hs_data[3], pat(3));

    // Address wrap 63 -> 0.
    clear_logs();
    start_burst(62, 4);
    wait_idle(50);
    chk("t2_a0", 64'(issue_log[0]), 64'(62));
    chk("t2_a1", 64'(issue_log[1]), 64'(63));
    chk("t2_a2", 64'(issue_log[2]), 64'(0));
    chk("t2_a3", 64'(issue_log[3]), 64'(1));
    chkrow("t2_row1", hs_data[1], pat(63));
    chkrow("t2_row2", hs_data[2], pat(0));

    // Length 0 means 64 rows.
    clear_logs();
    start_burst(5, 0);
    wait_idle(200);
    chk("t3_rows", 64'(hs_log.size()), 64'(64));
    chk("t3_done_cnt", 64'(done_log.size()), 64'(1));
    chk("t3_a_first", 64'(issue_log[0]), 64'(5));
    chk("t3_a58", 64'(issue_log[58]), 64'(63));
    chk("t3_a59", 64'(issue_log[59]), 64'(0));
    chk("t3_a_last", 64'(issue_log[63]), 64'(4));
    chkrow("t3_row59", hs_data[59], pat(0));

    // Consumer stall mid-burst with a continuously writing loader.
    clear_logs();
    start_burst(10, 16);
    wr_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_addr = AW'($urandom);
      wr_data = rand_row();
      tick();
    end
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_addr = AW'($urandom);
      wr_data = rand_row();
      tick();
    end
    chk("t4_buffered", 64'(issue_log.size() - hs_log.size()), 64'(3));
    chk("t4_wr_granted", 64'(wsb_low_cnt > 0), 64'(1));
    out_ready = 1'b1;
    wr_valid  = 1'b0;
    wait_idle(100);
    chk("t4_rows", 64'(hs_log.size()), 64'(16));

    // A loader write is returned by a later burst.
    wr_valid = 1'b1;
    wr_addr  = AW'(20);
    wr_data  = {16{32'h1234_5678}};
    tick();
    wr_valid = 1'b0;
    clear_logs();
    start_burst(20, 1);
    wait_idle(50);
    chkrow("t5_readback", hs_data[0], {16{32'h1234_5678}});

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      wr_valid  = ($urandom_range(0, 1) == 1);
      wr_addr   = AW'($urandom);
      wr_data   = rand_row();
      out_ready = ($urandom_range(0, 9) < 7);
      rd_start  = ($urandom_range(0, 7) == 0);
      rd_base   = AW'($urandom);
      rd_len    = 7'($urandom_range(0, 64));
      tick();
    end
    rd_start  = 1'b0;
    wr_valid  = 1'b0;
    out_ready = 1'b1;
    wait_idle(200);

    // Reset in the middle of a burst.
    start_burst(0, 30);
    out_ready = 1'b0;
    tick(4);
    out_ready = 1'b1;
    tick(2);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_reset_vals("rst_mid");
    tick();
    rst = 1'b0;
    tick();
    clear_logs();
    start_burst(7, 8);
    wait_idle(60);
    chk("t6_rows", 64'(hs_log.size()), 64'(8));
    chk("t6_done_cnt", 64'(done_log.size()), 64'(1));
    chk("t6_a_first", 64'(issue_log[0]), 64'(7));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
